// File: rtl/traffic_phase_scheduler.sv
// Tick-driven four-movement intersection phase scheduler (main, turn, side, ped)
// with demand latching, fixed service rotation and emergency preempt.
module traffic_phase_scheduler #(
  parameter int T_MAIN_G = 7,
  parameter int T_TURN_G = 5,
  parameter int T_SIDE_G = 3,
  parameter int T_PED    = 4,
  parameter int T_YEL    = 2,
  parameter int T_RED    = 1,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       turn_req,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] light_M,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       ped_walk,
  output logic [3:0] phase,
  output logic [2:0] pend
);

  typedef enum logic [3:0] {
    MAIN_G  = 4'd0,
    MAIN_Y  = 4'd1,
    TURN_G  = 4'd2,
    TURN_Y  = 4'd3,
    SIDE_G  = 4'd4,
    SIDE_Y  = 4'd5,
    PED_W   = 4'd6,
    ALL_RED = 4'd7,
    PREEMPT = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    FROM_MAIN = 2'd0,
    FROM_TURN = 2'd1,
    FROM_SIDE = 2'd2,
    FROM_PED  = 2'd3
  } from_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t         state, state_nx;
  from_t          nxt_from, from_nx;
  logic [CW-1:0]  count, limit;
  logic [2:0]     pend_nx;
  logic           expired;

  // Lamp pattern {M, MT, S, walk} for a state.
  function automatic logic [9:0] lamps(input state_t s);
    case (s)
      MAIN_G:  lamps = {GRN, GRN, RED, 1'b0};
      MAIN_Y:  lamps = {YEL, YEL, RED, 1'b0};
      TURN_G:  lamps = {RED, GRN, RED, 1'b0};
      TURN_Y:  lamps = {RED, YEL, RED, 1'b0};
      SIDE_G:  lamps = {RED, RED, GRN, 1'b0};
      SIDE_Y:  lamps = {RED, RED, YEL, 1'b0};
      PED_W:   lamps = {RED, RED, RED, 1'b1};
      PREEMPT: lamps = {GRN, RED, RED, 1'b0};
      default: lamps = {RED, RED, RED, 1'b0};
    endcase
  endfunction

  always_comb begin
    limit = '0;
    case (state)
      MAIN_G:                 limit = CW'(T_MAIN_G - 1);
      TURN_G:                 limit = CW'(T_TURN_G - 1);
      SIDE_G:                 limit = CW'(T_SIDE_G - 1);
      PED_W:                  limit = CW'(T_PED - 1);
      MAIN_Y, TURN_Y, SIDE_Y: limit = CW'(T_YEL - 1);
      ALL_RED:                limit = CW'(T_RED - 1);
      default:                limit = '0;
    endcase
  end

  assign expired = (count == limit);

  always_comb begin
    state_nx = state;
    from_nx  = nxt_from;
    if (tick) begin
      case (state)
        MAIN_G: begin
          if (emerg)                          state_nx = PREEMPT;
          else if (expired && pend != 3'b000) state_nx = MAIN_Y;
        end
        MAIN_Y: if (expired) begin state_nx = ALL_RED; from_nx = FROM_MAIN; end
        TURN_G: if (emerg || expired) state_nx = TURN_Y;
        TURN_Y: if (expired) begin state_nx = ALL_RED; from_nx = FROM_TURN; end
        SIDE_G: if (emerg || expired) state_nx = SIDE_Y;
        SIDE_Y: if (expired) begin state_nx = ALL_RED; from_nx = FROM_SIDE; end
        PED_W:  if (emerg || expired) begin state_nx = ALL_RED; from_nx = FROM_PED; end
        ALL_RED: begin
          if (expired) begin
            if (emerg) state_nx = PREEMPT;
            else begin
              // Rotation continues after the last served phase; MAIN ends every lap.
              case (nxt_from)
                FROM_MAIN: state_nx = pend[0] ? TURN_G : pend[1] ? SIDE_G :
                                      pend[2] ? PED_W : MAIN_G;
                FROM_TURN: state_nx = pend[1] ? SIDE_G : pend[2] ? PED_W : MAIN_G;
                FROM_SIDE: state_nx = pend[2] ? PED_W : MAIN_G;
                default:   state_nx = MAIN_G;
              endcase
            end
          end
        end
        PREEMPT: if (!emerg) state_nx = MAIN_G;
        default: state_nx = ALL_RED;
      endcase
    end
  end

  // Demand latches: clearing on entry to the served phase beats a same-cycle set.
  always_comb begin
    pend_nx[0] = (pend[0] | (turn_req & (state != TURN_G)))
                 & ~((state_nx == TURN_G) & (state != TURN_G));
    pend_nx[1] = (pend[1] | (side_req & (state != SIDE_G)))
                 & ~((state_nx == SIDE_G) & (state != SIDE_G));
    pend_nx[2] = (pend[2] | (ped_req & (state != PED_W)))
                 & ~((state_nx == PED_W) & (state != PED_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALL_RED;
      nxt_from <= FROM_MAIN;
      count    <= '0;
      pend     <= 3'b000;
      light_M  <= RED;
      light_MT <= RED;
      light_S  <= RED;
      ped_walk <= 1'b0;
    end else begin
      state    <= state_nx;
      nxt_from <= from_nx;
      pend     <= pend_nx;
      if (state_nx != state)     count <= '0;
      else if (tick && !expired) count <= count + 1'b1;
      {light_M, light_MT, light_S, ped_walk} <= lamps(state_nx);
    end
  end

  assign phase = state;

endmodule
